// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared definitions for the SPI transmit sequencer: byte width, chip-select
// timing defaults and the controller state encoding.
package spi_xfer_ctrl_pkg;

   localparam int unsigned SPI_BYTE_W   = 8;
   localparam int unsigned CS_SETUP_DEF = 2;
   localparam int unsigned CS_HOLD_DEF  = 2;
   localparam int unsigned CS_CNT_W     = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StSetup = 2'b01,
      StShift = 2'b10,
      StHold  = 2'b11
   } state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// Circular byte buffer with combinational head; pointers wrap modulo Depth.
// Callers never push when full or pop when empty.
module spi_byte_fifo
   import spi_xfer_ctrl_pkg::*;
#(
   parameter int unsigned Depth = 8,
   localparam int unsigned Cw = $clog2(Depth + 1),
   localparam int unsigned Aw = $clog2(Depth)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [SPI_BYTE_W-1:0] wdata_i,
   input  logic                  pop_i,
   output logic [SPI_BYTE_W-1:0] rdata_o,
   output logic [Cw-1:0]         count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic [SPI_BYTE_W-1:0] mem_q [Depth];
   logic [Aw-1:0]         wr_ptr_q, rd_ptr_q;
   logic [Cw-1:0]         count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + Cw'(1);
      end else if (!push_i && pop_i) begin
         count_d = count_q - Cw'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + Aw'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + Aw'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == Cw'(Depth));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI host transmit sequencer: buffers bytes, then frames them with cs_n and
// streams them gap-free to the byte shifter via tx_start/tx_cmd/tx_done.
module spi_xfer_ctrl
   import spi_xfer_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned CS_SETUP = CS_SETUP_DEF,
   parameter int unsigned CS_HOLD  = CS_HOLD_DEF,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [SPI_BYTE_W-1:0] wr_data,
   output logic                  full,
   output logic [CW-1:0]         count,
   output logic                  wr_err,
   input  logic                  go,
   output logic                  go_err,
   output logic                  busy,
   output logic                  xfer_done,
   output logic                  cs_n,
   output logic                  tx_start,
   output logic [SPI_BYTE_W-1:0] tx_cmd,
   input  logic                  tx_done
);

   localparam logic [CS_CNT_W-1:0] SetupLast = CS_CNT_W'(CS_SETUP - 1);
   localparam logic [CS_CNT_W-1:0] HoldLast  = CS_CNT_W'(CS_HOLD - 1);

   state_e                state_q, state_d;
   logic [CS_CNT_W-1:0]   cnt_q, cnt_d;
   logic                  cs_n_q, cs_n_d;
   logic                  tx_start_q, tx_start_d;
   logic [SPI_BYTE_W-1:0] tx_cmd_q, tx_cmd_d;
   logic                  wr_err_q, wr_err_d;
   logic                  go_err_q, go_err_d;
   logic                  xfer_done_q, xfer_done_d;

   logic                  idle, go_ok, push, pop, empty;
   logic [SPI_BYTE_W-1:0] head;

   // A write arriving with go on an empty buffer bypasses straight to tx_cmd.
   assign idle  = (state_q == StIdle);
   assign go_ok = idle && go && (!empty || wr_en);
   assign push  = idle && wr_en && !full && !(go_ok && empty);
   assign pop   = (go_ok && !empty) || (state_q == StShift && tx_done && !empty);

   spi_byte_fifo #(
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i (wr_data),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (go_ok) state_d = StSetup;
         StSetup: if (cnt_q == SetupLast) state_d = StShift;
         StShift: if (tx_done && empty) state_d = StHold;
         StHold:  if (cnt_q == HoldLast) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      cs_n_d      = cs_n_q;
      tx_start_d  = tx_start_q;
      tx_cmd_d    = tx_cmd_q;
      wr_err_d    = wr_en && (!idle || full);
      go_err_d    = go && !go_ok;
      xfer_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (go_ok) begin
               cs_n_d   = 1'b0;
               cnt_d    = '0;
               tx_cmd_d = empty ? wr_data : head;
            end
         end
         StSetup: begin
            if (cnt_q == SetupLast) begin
               tx_start_d = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CS_CNT_W'(1);
            end
         end
         StShift: begin
            // Next byte lands before the shifter wraps to index 0.
            if (tx_done) begin
               if (!empty) tx_cmd_d   = head;
               else        tx_start_d = 1'b0;
            end
         end
         StHold: begin
            if (cnt_q == HoldLast) begin
               cs_n_d      = 1'b1;
               xfer_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CS_CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         cs_n_q      <= 1'b1;
         tx_start_q  <= 1'b0;
         tx_cmd_q    <= '0;
         wr_err_q    <= 1'b0;
         go_err_q    <= 1'b0;
         xfer_done_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         cs_n_q      <= cs_n_d;
         tx_start_q  <= tx_start_d;
         tx_cmd_q    <= tx_cmd_d;
         wr_err_q    <= wr_err_d;
         go_err_q    <= go_err_d;
         xfer_done_q <= xfer_done_d;
      end
   end

   assign cs_n      = cs_n_q;
   assign tx_start  = tx_start_q;
   assign tx_cmd    = tx_cmd_q;
   assign wr_err    = wr_err_q;
   assign go_err    = go_err_q;
   assign xfer_done = xfer_done_q;
   assign busy      = !idle || xfer_done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a negedge byte-shifter model that
// records every bit it puts on the wire while cs_n is low.
module tb_spi_xfer_ctrl;

   localparam int unsigned DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       go = 1'b0;
   logic       full, wr_err, go_err, busy, xfer_done, cs_n, tx_start, tx_done;
   logic [3:0] count;
   logic [7:0] tx_cmd;

   int n_vec = 0;
   int n_err = 0;

   spi_xfer_ctrl #(
      .DEPTH    (DEPTH),
      .CS_SETUP (2),
      .CS_HOLD  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .count     (count),
      .wr_err    (wr_err),
      .go        (go),
      .go_err    (go_err),
      .busy      (busy),
      .xfer_done (xfer_done),
      .cs_n      (cs_n),
      .tx_start  (tx_start),
      .tx_cmd    (tx_cmd),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Shifter model: idles at index 0 driving tx_cmd[7], steps on negedge.
   logic [2:0] idx = 3'd0;
   logic       sdo = 1'b0;
   logic       bits[$];
   logic       ts_prev = 1'b0;
   int         rise_cyc = 0, fall_cyc = 0, n_rise = 0, n_done = 0;

   assign tx_done = (idx == 3'd7);

   always @(negedge clk) begin
      if (!cs_n && (tx_start || idx != 3'd0)) bits.push_back(sdo);
      if (tx_start) begin
         sdo <= tx_cmd[~(idx + 3'd1)];
         idx <= idx + 3'd1;
      end else begin
         sdo <= tx_cmd[7];
         idx <= 3'd0;
      end
      ts_prev <= tx_start;
      if (tx_start && !ts_prev) begin
         rise_cyc <= cyc;
         n_rise   <= n_rise + 1;
      end
      if (!tx_start && ts_prev) fall_cyc <= cyc;
      if (xfer_done) n_done <= n_done + 1;
   end

   function automatic logic [7:0] got_byte(input int base);
      logic [7:0] r = 8'hxx;
      if (bits.size() >= base + 8)
         for (int j = 0; j < 8; j++) r[7-j] = bits[base+j];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic wait_idle(output bit to);
      int k = 0;
      while (busy && k < 400) begin
         step();
         k++;
      end
      to = busy;
   endtask

   task automatic wait_bits(input int n, output bit to);
      int k = 0;
      while (bits.size() < n && k < 400) begin
         step();
         k++;
      end
      to = (bits.size() < n);
   endtask

   task automatic test_reset();
      step();
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if ({cs_n, tx_start} !== 2'b10) begin n_err++; $display("FAIL reset_cs_tx: got %b want 10", {cs_n, tx_start}); end
      n_vec++; if (tx_cmd !== 8'h00) begin n_err++; $display("FAIL reset_tx_cmd: got %h want 00", tx_cmd); end
      n_vec++; if ({wr_err, go_err, xfer_done} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {wr_err, go_err, xfer_done}); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      int b0 = bits.size();
      int d0 = n_done;
      int r0 = n_rise;
      bit to;
      push(8'hA5);
      n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", count); end
      pulse_go();
      n_vec++; if ({cs_n, busy} !== 2'b01) begin n_err++; $display("FAIL single_start: cs_n,busy got %b want 01", {cs_n, busy}); end
      n_vec++; if (tx_cmd !== 8'hA5) begin n_err++; $display("FAIL single_tx_cmd: got %h want a5", tx_cmd); end
      n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", count); end
      wait_idle(to);
      n_vec++; if (to) begin n_err++; $display("FAIL single_timeout: busy still %b want 0", busy); end
      n_vec++; if (bits.size() - b0 != 8) begin n_err++; $display("FAIL single_nbits: got %0d want 8", bits.size() - b0); end
      n_vec++; if (got_byte(b0) !== 8'hA5) begin n_err++; $display("FAIL single_byte: got %h want a5", got_byte(b0)); end
      n_vec++; if (n_done - d0 != 1) begin n_err++; $display("FAIL single_done: got %0d pulses want 1", n_done - d0); end
      n_vec++; if (n_rise - r0 != 1 || fall_cyc - rise_cyc + 1 != 8) begin n_err++; $display("FAIL single_txspan: rises %0d span %0d want 1 8", n_rise - r0, fall_cyc - rise_cyc + 1); end
      n_vec++; if ({cs_n, busy, count} !== {1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL single_end: cs_n,busy,count got %b,%b,%0d want 1,0,0", cs_n, busy, count); end
   endtask

   task automatic test_stream();
      logic [7:0] exp [3] = '{8'h3C, 8'hFF, 8'h01};
      int b0 = bits.size();
      int r0 = n_rise;
      bit to;
      for (int i = 0; i < 3; i++) push(exp[i]);
      pulse_go();
      wait_idle(to);
      n_vec++; if (to) begin n_err++; $display("FAIL stream_timeout: busy still %b want 0", busy); end
      n_vec++; if (bits.size() - b0 != 24) begin n_err++; $display("FAIL stream_nbits: got %0d want 24", bits.size() - b0); end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (got_byte(b0 + 8*i) !== exp[i]) begin n_err++; $display("FAIL stream_byte%0d: got %h want %h", i, got_byte(b0 + 8*i), exp[i]); end
      end
      n_vec++; if (n_rise - r0 != 1 || fall_cyc - rise_cyc + 1 != 24) begin n_err++; $display("FAIL stream_txspan: rises %0d span %0d want 1 24", n_rise - r0, fall_cyc - rise_cyc + 1); end
   endtask

   task automatic test_full();
      int b0;
      bit to;
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i * 17));
      n_vec++; if ({full, count} !== {1'b1, 4'd8}) begin n_err++; $display("FAIL full_flag: full,count got %b,%0d want 1,8", full, count); end
      push(8'hEE);
      n_vec++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL full_wr_err: got %b want 1", wr_err); end
      n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", count); end
      step();
      n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL full_wr_err_pulse: got %b want 0", wr_err); end
      b0 = bits.size();
      pulse_go();
      wait_idle(to);
      n_vec++; if (to || bits.size() - b0 != 64) begin n_err++; $display("FAIL full_nbits: got %0d timeout %b want 64 0", bits.size() - b0, to); end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (got_byte(b0 + 8*i) !== 8'h10 + 8'(i * 17)) begin n_err++; $display("FAIL full_byte%0d: got %h want %h", i, got_byte(b0 + 8*i), 8'h10 + 8'(i * 17)); end
      end
   endtask

   task automatic test_go_empty();
      int b0;
      bit to;
      pulse_go();
      n_vec++; if (go_err !== 1'b1) begin n_err++; $display("FAIL empty_go_err: got %b want 1", go_err); end
      n_vec++; if ({cs_n, busy} !== 2'b10) begin n_err++; $display("FAIL empty_idle: cs_n,busy got %b want 10", {cs_n, busy}); end
      step();
      n_vec++; if ({go_err, cs_n} !== 2'b01) begin n_err++; $display("FAIL empty_after: go_err,cs_n got %b want 01", {go_err, cs_n}); end
      b0 = bits.size();
      wr_en = 1'b1;
      wr_data = 8'h81;
      go = 1'b1;
      step();
      wr_en = 1'b0;
      go = 1'b0;
      n_vec++; if ({busy, go_err, wr_err, count} !== {3'b100, 4'd0}) begin n_err++; $display("FAIL bypass_start: busy,go_err,wr_err,count got %b%b%b,%0d want 100,0", busy, go_err, wr_err, count); end
      n_vec++; if (tx_cmd !== 8'h81) begin n_err++; $display("FAIL bypass_tx_cmd: got %h want 81", tx_cmd); end
      wait_idle(to);
      n_vec++; if (to || bits.size() - b0 != 8 || got_byte(b0) !== 8'h81) begin n_err++; $display("FAIL bypass_byte: got %h (%0d bits) want 81 (8 bits)", got_byte(b0), bits.size() - b0); end
   endtask

   task automatic test_busy_err();
      int b0 = bits.size();
      int d0 = n_done;
      int k = 0;
      bit to;
      push(8'h5A);
      push(8'hC3);
      pulse_go();
      while (!tx_start && k < 50) begin step(); k++; end
      n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL busy_tx_start: got %b want 1", tx_start); end
      step();
      step();
      wr_en = 1'b1;
      wr_data = 8'hEE;
      go = 1'b1;
      step();
      wr_en = 1'b0;
      go = 1'b0;
      n_vec++; if ({wr_err, go_err} !== 2'b11) begin n_err++; $display("FAIL busy_errs: wr_err,go_err got %b want 11", {wr_err, go_err}); end
      n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL busy_count: got %0d want 1", count); end
      wait_idle(to);
      n_vec++; if (to || bits.size() - b0 != 16) begin n_err++; $display("FAIL busy_nbits: got %0d want 16", bits.size() - b0); end
      n_vec++; if (got_byte(b0) !== 8'h5A || got_byte(b0 + 8) !== 8'hC3) begin n_err++; $display("FAIL busy_bytes: got %h %h want 5a c3", got_byte(b0), got_byte(b0 + 8)); end
      n_vec++; if (n_done - d0 != 1 || count !== 4'd0) begin n_err++; $display("FAIL busy_end: done %0d count %0d want 1 0", n_done - d0, count); end
   endtask

   task automatic test_reset_mid();
      int b0 = bits.size();
      bit to;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      pulse_go();
      wait_bits(b0 + 10, to);
      n_vec++; if (to) begin n_err++; $display("FAIL rstmid_timeout: got %0d bits want >=10", bits.size() - b0); end
      rst = 1'b1;
      #1;
      n_vec++; if ({cs_n, tx_start} !== 2'b10) begin n_err++; $display("FAIL rstmid_async: cs_n,tx_start got %b want 10", {cs_n, tx_start}); end
      n_vec++; if ({count, busy} !== {4'd0, 1'b0}) begin n_err++; $display("FAIL rstmid_state: count %0d busy %b want 0 0", count, busy); end
      step();
      rst = 1'b0;
      step();
      b0 = bits.size();
      push(8'h96);
      pulse_go();
      wait_idle(to);
      n_vec++; if (to || bits.size() - b0 != 8 || got_byte(b0) !== 8'h96) begin n_err++; $display("FAIL rstmid_after: got %h (%0d bits) want 96 (8 bits)", got_byte(b0), bits.size() - b0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_full();
      test_go_empty();
      test_busy_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
